// File: rtl/seg2_scan_driver_pkg.sv
// Shared constants for the two-digit seven-segment scan driver:
// glyph codes, row-select codes and conversion FSM states.
package seg2_scan_driver_pkg;

  localparam logic [7:0] SEG_0    = 8'hFC;
  localparam logic [7:0] SEG_1    = 8'h60;
  localparam logic [7:0] SEG_2    = 8'hDA;
  localparam logic [7:0] SEG_3    = 8'hF2;
  localparam logic [7:0] SEG_4    = 8'h66;
  localparam logic [7:0] SEG_5    = 8'hB6;
  localparam logic [7:0] SEG_6    = 8'hBE;
  localparam logic [7:0] SEG_7    = 8'hE0;
  localparam logic [7:0] SEG_8    = 8'hFE;
  localparam logic [7:0] SEG_9    = 8'hF6;
  localparam logic [7:0] SEG_DASH = 8'b0000_0010;
  localparam logic [7:0] SEG_OFF  = 8'b0000_0000;

  localparam logic [1:0] ROW_ONES = 2'b10;
  localparam logic [1:0] ROW_TENS = 2'b01;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    UPDATE = 2'd2
  } conv_state_e;

  function automatic logic [7:0] digit_glyph(input logic [3:0] digit);
    logic [7:0] glyph;
    case (digit)
      4'd0:    glyph = SEG_0;
      4'd1:    glyph = SEG_1;
      4'd2:    glyph = SEG_2;
      4'd3:    glyph = SEG_3;
      4'd4:    glyph = SEG_4;
      4'd5:    glyph = SEG_5;
      4'd6:    glyph = SEG_6;
      4'd7:    glyph = SEG_7;
      4'd8:    glyph = SEG_8;
      4'd9:    glyph = SEG_9;
      default: glyph = SEG_OFF;
    endcase
    return glyph;
  endfunction

endpackage

// File: rtl/seg2_scan_driver_bin2bcd_seq.sv
// Iterative double-dabble: start latches bin_in and clears the BCD register,
// then VAL_W add-3/shift iterations leave two BCD digits on tens/ones.
module bin2bcd_seq #(
  parameter int VAL_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [VAL_W-1:0] bin_in,
  output logic             done,
  output logic [3:0]       tens,
  output logic [3:0]       ones
);

  localparam int             CW   = $clog2(VAL_W);
  localparam logic [CW-1:0]  LAST = CW'(VAL_W - 1);

  logic [VAL_W-1:0] bin_q, bin_d;
  logic [7:0]       bcd_q, bcd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             active_q, active_d;
  logic [3:0]       tens_adj, ones_adj;

  always_comb begin
    ones_adj = (bcd_q[3:0] >= 4'd5) ? bcd_q[3:0] + 4'd3 : bcd_q[3:0];
    tens_adj = (bcd_q[7:4] >= 4'd5) ? bcd_q[7:4] + 4'd3 : bcd_q[7:4];
    bin_d    = bin_q;
    bcd_d    = bcd_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    if (start) begin
      bin_d    = bin_in;
      bcd_d    = '0;
      cnt_d    = '0;
      active_d = 1'b1;
    end else if (active_q) begin
      {bcd_d, bin_d} = {tens_adj, ones_adj, bin_q} << 1;
      cnt_d          = cnt_q + CW'(1);
      if (cnt_q == LAST) active_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q    <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      bin_q    <= bin_d;
      bcd_q    <= bcd_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

  // done flags the cycle whose closing edge performs the final iteration.
  assign done = active_q && (cnt_q == LAST);
  assign tens = bcd_q[7:4];
  assign ones = bcd_q[3:0];

endmodule

// File: rtl/seg2_scan_driver.sv
// Two-digit multiplexed seven-segment driver with valid/busy value intake.
// Optional macro LEADING_ZERO_BLANK_EN blanks a zero tens digit.
module seg2_scan_driver #(
  parameter int SCAN_DIV = 50000,
  parameter int VAL_W    = 7,
  parameter int MAX_VAL  = 99
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [VAL_W-1:0] value_in,
  input  logic             value_valid,
  output logic             busy,
  input  logic             blank,
  output logic             overflow,
  output logic [1:0]       segment_row,
  output logic [7:0]       segment_col
);

  import seg2_scan_driver_pkg::*;

  localparam int            PW        = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);

  conv_state_e   state_q, state_d;
  logic          start, conv_done;
  logic [3:0]    bcd_tens, bcd_ones;
  logic          ovf_pend_q, ovf_pend_d;
  logic [3:0]    tens_q, tens_d, ones_q, ones_d;
  logic          overflow_q, overflow_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          sel_q, sel_d;
  logic [1:0]    row_q, row_d;
  logic [7:0]    col_q, col_d;
  logic [7:0]    tens_glyph, ones_glyph;

  bin2bcd_seq #(.VAL_W(VAL_W)) u_bin2bcd (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .bin_in (value_in),
    .done   (conv_done),
    .tens   (bcd_tens),
    .ones   (bcd_ones)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (value_valid) state_d = SHIFT;
      SHIFT:   if (conv_done)   state_d = UPDATE;
      UPDATE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy  = (state_q != IDLE);
    start = (state_q == IDLE) && value_valid;
  end

  always_comb begin
    ovf_pend_d = start ? (value_in > VAL_W'(MAX_VAL)) : ovf_pend_q;
    tens_d     = tens_q;
    ones_d     = ones_q;
    overflow_d = overflow_q;
    if (state_q == UPDATE) begin
      tens_d     = bcd_tens;
      ones_d     = bcd_ones;
      overflow_d = ovf_pend_q;
    end

    presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + PW'(1);
    sel_d   = (presc_q == PRESC_MAX) ? ~sel_q : sel_q;
    row_d   = sel_d ? ROW_TENS : ROW_ONES;

    ones_glyph = overflow_q ? SEG_DASH : digit_glyph(ones_q);
`ifdef LEADING_ZERO_BLANK_EN
    tens_glyph = overflow_q ? SEG_DASH :
                 (tens_q == 4'd0) ? SEG_OFF : digit_glyph(tens_q);
`else
    tens_glyph = overflow_q ? SEG_DASH : digit_glyph(tens_q);
`endif
    // Column follows the next-state select so row and column change together.
    col_d = blank ? SEG_OFF : (sel_d ? tens_glyph : ones_glyph);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_pend_q <= 1'b0;
      tens_q     <= '0;
      ones_q     <= '0;
      overflow_q <= 1'b0;
      presc_q    <= '0;
      sel_q      <= 1'b0;
      row_q      <= ROW_ONES;
      col_q      <= SEG_0;
    end else begin
      ovf_pend_q <= ovf_pend_d;
      tens_q     <= tens_d;
      ones_q     <= ones_d;
      overflow_q <= overflow_d;
      presc_q    <= presc_d;
      sel_q      <= sel_d;
      row_q      <= row_d;
      col_q      <= col_d;
    end
  end

  assign overflow    = overflow_q;
  assign segment_row = row_q;
  assign segment_col = col_q;

endmodule

// File: tb/tb_seg2_scan_driver.sv
// Self-checking bench for seg2_scan_driver: directed scenarios plus random traffic
// compared every cycle against an arithmetic (value/10, value%10) display model.
`timescale 1ns/1ps
module tb_seg2_scan_driver;

  localparam int SCAN_DIV = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] value_in;
  logic       value_valid;
  logic       busy;
  logic       blank;
  logic       overflow;
  logic [1:0] segment_row;
  logic [7:0] segment_col;

  always #5 clk = ~clk;

  seg2_scan_driver #(.SCAN_DIV(SCAN_DIV), .VAL_W(7), .MAX_VAL(99)) dut (
    .clk         (clk),
    .rst         (rst),
    .value_in    (value_in),
    .value_valid (value_valid),
    .busy        (busy),
    .blank       (blank),
    .overflow    (overflow),
    .segment_row (segment_row),
    .segment_col (segment_col)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: edges since reset, acceptance edge, latched and committed values.
  int   edge_k  = 0;
  int   acc     = -1;
  int   lat_val = 0;
  int   com_val = 0;
  bit   com_ovf = 1'b0;
  logic [1:0] exp_row;
  logic [7:0] exp_col;
  logic       exp_busy;
  logic       exp_ovf;

  logic [7:0] glyph_tab [10] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66,
                                 8'hB6, 8'hBE, 8'hE0, 8'hFE, 8'hF6};

  function automatic logic [7:0] slot_glyph(input bit tens_slot, input int val, input bit ovf);
    if (ovf) return 8'h02;
    if (tens_slot) begin
`ifdef LEADING_ZERO_BLANK_EN
      if (val / 10 == 0) return 8'h00;
`endif
      return glyph_tab[val / 10];
    end
    return glyph_tab[val % 10];
  endfunction

  task automatic model_edge(input bit r, input bit v, input bit b, input int val);
    int vis_val;
    bit vis_ovf;
    bit sel;
    vis_val = com_val;
    vis_ovf = com_ovf;
    if (r) begin
      edge_k  = 0;
      acc     = -1;
      com_val = 0;
      com_ovf = 1'b0;
      exp_row = 2'b10;
      exp_col = 8'hFC;
    end else begin
      edge_k++;
      if (acc >= 0 && edge_k == acc + 8) begin
        com_val = lat_val;
        com_ovf = (lat_val > 99);
        acc     = -1;
      end else if (acc < 0 && v) begin
        acc     = edge_k;
        lat_val = val;
      end
      sel     = ((edge_k / SCAN_DIV) % 2) == 1;
      exp_row = sel ? 2'b01 : 2'b10;
      exp_col = b ? 8'h00 : slot_glyph(sel, vis_val, vis_ovf);
    end
    exp_busy = (acc >= 0);
    exp_ovf  = com_ovf;
  endtask

  task automatic checkOutput(input string tag);
    total++;
    assert (segment_row === exp_row) else begin
      bad++;
      $error("[TB] FAIL %s row: observed=%b expected=%b (edge %0d)", tag, segment_row, exp_row, edge_k);
    end
    total++;
    assert (segment_col === exp_col) else begin
      bad++;
      $error("[TB] FAIL %s col: observed=%h expected=%h (edge %0d)", tag, segment_col, exp_col, edge_k);
    end
    total++;
    assert (busy === exp_busy) else begin
      bad++;
      $error("[TB] FAIL %s busy: observed=%b expected=%b (edge %0d)", tag, busy, exp_busy, edge_k);
    end
    total++;
    assert (overflow === exp_ovf) else begin
      bad++;
      $error("[TB] FAIL %s overflow: observed=%b expected=%b (edge %0d)", tag, overflow, exp_ovf, edge_k);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit v, input int val, input bit b, input string tag);
    rst         = r;
    value_valid = v;
    value_in    = 7'(val);
    blank       = b;
    @(posedge clk);
    model_edge(r, v, b, val);
    #1;
    checkOutput(tag);
  endtask

  task automatic idleCycles(input int n, input string tag);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 0, 1'b0, tag);
  endtask

  task automatic showValue(input int val, input string tag);
    applyStimulus(1'b0, 1'b1, val, 1'b0, tag);
    idleCycles(20, tag);
  endtask

  initial begin
    int bval [6] = '{0, 9, 10, 99, 100, 127};
    rst = 1'b1; value_valid = 1'b0; value_in = '0; blank = 1'b0;

    $display("[TB] reset and idle scan");
    applyStimulus(1'b1, 1'b0, 0, 1'b0, "reset");
    applyStimulus(1'b1, 1'b0, 0, 1'b0, "reset");
    idleCycles(16, "idle_scan");

    $display("[TB] basic conversions");
    showValue(59, "val59");
    showValue(100, "val100");
    showValue(7, "val7");

    $display("[TB] value_valid while busy is dropped");
    applyStimulus(1'b0, 1'b1, 59, 1'b0, "drop_accept");
    idleCycles(2, "drop_busy");
    applyStimulus(1'b0, 1'b1, 42, 1'b0, "drop_ignored");
    for (int i = 0; i < 12 && exp_busy; i++) applyStimulus(1'b0, 1'b0, 0, 1'b0, "drop_wait");
    idleCycles(12, "drop_still59");
    showValue(42, "val42");

    $display("[TB] blanking");
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 0, 1'b1, "blank_on");
    idleCycles(8, "blank_off");

    $display("[TB] reset during conversion");
    applyStimulus(1'b0, 1'b1, 85, 1'b0, "abort_accept");
    idleCycles(3, "abort_shift");
    applyStimulus(1'b1, 1'b0, 0, 1'b0, "abort_reset");
    idleCycles(16, "abort_after");

    $display("[TB] boundary values");
    foreach (bval[i]) showValue(bval[i], "boundary");

    $display("[TB] back-to-back valid");
    for (int i = 0; i < 30; i++) applyStimulus(1'b0, 1'b1, (i < 15) ? 33 : 68, 1'b0, "b2b");
    idleCycles(10, "b2b_tail");

    $display("[TB] random traffic");
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b0, ($urandom_range(0, 3) == 0), int'($urandom_range(0, 127)),
                    ($urandom_range(0, 9) == 0), "random");
    end
    idleCycles(20, "random_tail");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
